// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_pkg -- 640x480@60 timing constants and 160x120 framebuffer geometry
// Rev 1.0
// ----------------------------------------------------------------------
package vga_pkg;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int ADDR_W  = 15;
  localparam int CNT_W   = 10;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  // row*160 built from two shifts so no multiplier is needed
  function automatic fb_addr_t fb_addr(input logic [6:0] row, input logic [7:0] col);
    fb_addr_t w_row;
    w_row = {8'd0, row};
    return (w_row << 7) + (w_row << 5) + {7'd0, col};
  endfunction
endpackage
`default_nettype wire

// File: rtl/vga_timing_counter.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_timing_counter -- pixel phase, h/v counters and raw timing decode
// Rev 1.0
// ----------------------------------------------------------------------
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       o_phase,
  output logic [7:0] o_col,
  output logic [6:0] o_row,
  output logic       o_visible,
  output logic       o_hs_raw,
  output logic       o_vs_raw,
  output logic       o_frame_wrap
);
  localparam cnt_t c_H_LAST = cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t c_V_LAST = cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t c_H_VIS  = cnt_t'(H_VIS);
  localparam cnt_t c_V_VIS  = cnt_t'(V_VIS);
  localparam cnt_t c_HS_BEG = cnt_t'(H_VIS + H_FP);
  localparam cnt_t c_HS_END = cnt_t'(H_VIS + H_FP + H_SYNC);
  localparam cnt_t c_VS_BEG = cnt_t'(V_VIS + V_FP);
  localparam cnt_t c_VS_END = cnt_t'(V_VIS + V_FP + V_SYNC);

  logic r_phase;
  cnt_t r_hcnt;
  cnt_t r_vcnt;
  logic w_h_last;
  logic w_v_last;

  assign w_h_last = (r_hcnt == c_H_LAST);
  assign w_v_last = (r_vcnt == c_V_LAST);

  // counters only move on the pixel tick (phase=1)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= 1'b0;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_phase <= ~r_phase;
      if (r_phase) begin
        if (w_h_last) begin
          r_hcnt <= '0;
          r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end
  end

  assign o_phase      = r_phase;
  assign o_col        = r_hcnt[9:2];
  assign o_row        = r_vcnt[8:2];
  assign o_visible    = (r_hcnt < c_H_VIS) && (r_vcnt < c_V_VIS);
  assign o_hs_raw     = !((r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END));
  assign o_vs_raw     = !((r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END));
  assign o_frame_wrap = r_phase && w_h_last && w_v_last;
endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_scanout -- 160x120x3bpp framebuffer scanned out as 640x480 VGA
// Rev 1.0
// ----------------------------------------------------------------------
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] o_fb_raddr,
  input  logic [2:0]        i_fb_rdata,
  output logic              o_vga_clk,
  output logic              o_vga_hs,
  output logic              o_vga_vs,
  output logic              o_vga_blank_n,
  output logic [7:0]        o_vga_r,
  output logic [7:0]        o_vga_g,
  output logic [7:0]        o_vga_b,
  output logic              o_frame_start
);
  logic       w_phase;
  logic [7:0] w_col;
  logic [6:0] w_row;
  logic       w_visible;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic       w_frame_wrap;

  fb_addr_t   r_fb_raddr;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;
  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;
  logic       r_frame_start;

  vga_timing_counter #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .o_phase      (w_phase),
    .o_col        (w_col),
    .o_row        (w_row),
    .o_visible    (w_visible),
    .o_hs_raw     (w_hs_raw),
    .o_vs_raw     (w_vs_raw),
    .o_frame_wrap (w_frame_wrap)
  );

  // Address goes out mid-pixel; its read data arrives in time for the
  // tick that closes the same pixel, so every pin moves together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fb_raddr    <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_r           <= 8'h00;
      r_g           <= 8'h00;
      r_b           <= 8'h00;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (!w_phase) begin
        r_fb_raddr <= w_visible ? fb_addr(w_row, w_col) : '0;
      end
      if (w_phase) begin
        r_hs      <= w_hs_raw;
        r_vs      <= w_vs_raw;
        r_blank_n <= w_visible;
        r_r       <= (w_visible && i_fb_rdata[2]) ? 8'hFF : 8'h00;
        r_g       <= (w_visible && i_fb_rdata[1]) ? 8'hFF : 8'h00;
        r_b       <= (w_visible && i_fb_rdata[0]) ? 8'hFF : 8'h00;
      end
    end
  end

  assign o_fb_raddr    = r_fb_raddr;
  assign o_vga_clk     = w_phase;
  assign o_vga_hs      = r_hs;
  assign o_vga_vs      = r_vs;
  assign o_vga_blank_n = r_blank_n;
  assign o_vga_r       = r_r;
  assign o_vga_g       = r_g;
  assign o_vga_b       = r_b;
  assign o_frame_start = r_frame_start;
endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_vga_scanout -- default-timing and shrunk-timing scanouts checked
// against a pixel-time reference model. Rev 1.0
// ----------------------------------------------------------------------
module tb_vga_scanout;
  localparam int S_HV = 40, S_HF = 4, S_HS = 8, S_HB = 8;
  localparam int S_VV = 12, S_VF = 2, S_VS = 3, S_VB = 3;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME_CLK = 2 * S_HT * S_VT;
  localparam logic [43:0] RST_BUS = {1'b0, 15'd0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  logic [14:0] d_raddr, s_raddr;
  logic [2:0]  d_rdata, s_rdata;
  logic        d_vclk, d_hs, d_vs, d_bn, d_fs;
  logic        s_vclk, s_hs, s_vs, s_bn, s_fs;
  logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;
  logic [43:0] d_bus, s_bus;
  logic [2:0]  mem_s [0:19199];

  int kd = 0;
  int ks = 0;
  int errors = 0;
  int checks = 0;

  vga_scanout u_dflt (
    .clk (clk), .reset (rst_d), .o_fb_raddr (d_raddr), .i_fb_rdata (d_rdata),
    .o_vga_clk (d_vclk), .o_vga_hs (d_hs), .o_vga_vs (d_vs), .o_vga_blank_n (d_bn),
    .o_vga_r (d_r), .o_vga_g (d_g), .o_vga_b (d_b), .o_frame_start (d_fs)
  );

  vga_scanout #(
    .H_VIS (S_HV), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_VIS (S_VV), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
  ) u_small (
    .clk (clk), .reset (rst_s), .o_fb_raddr (s_raddr), .i_fb_rdata (s_rdata),
    .o_vga_clk (s_vclk), .o_vga_hs (s_hs), .o_vga_vs (s_vs), .o_vga_blank_n (s_bn),
    .o_vga_r (s_r), .o_vga_g (s_g), .o_vga_b (s_b), .o_frame_start (s_fs)
  );

  assign d_rdata = d_raddr[2:0];
  assign s_rdata = mem_s[s_raddr];
  assign d_bus = {d_vclk, d_raddr, d_hs, d_vs, d_bn, d_r, d_g, d_b, d_fs};
  assign s_bus = {s_vclk, s_raddr, s_hs, s_vs, s_bn, s_r, s_g, s_b, s_fs};

  // clocks elapsed since each DUT left reset; 0 is the reset-state cycle
  always @(posedge clk) begin
    kd <= rst_d ? 0 : kd + 1;
    ks <= rst_s ? 0 : ks + 1;
  end

  function automatic logic [14:0] pix_addr(input int h, input int v);
    return 15'((v / 4) * 160 + h / 4);
  endfunction

  // Pin bundle expected k clocks after reset: pixel n is fetched at k=2n+1
  // and drives the pins from k=2n+2.
  function automatic logic [43:0] model(input bit sm, input int k);
    int hv, hf, hsw, ht, vv, vf, vsw, vt, p, h, v;
    logic [14:0] ra, pa;
    logic [2:0]  c;
    logic        hs, vs, bn, fs;
    logic [23:0] rgb;
    if (sm) begin
      hv = S_HV; hf = S_HF; hsw = S_HS; ht = S_HT;
      vv = S_VV; vf = S_VF; vsw = S_VS; vt = S_VT;
    end else begin
      hv = 640; hf = 16; hsw = 96; ht = 800;
      vv = 480; vf = 10; vsw = 2;  vt = 525;
    end
    ra = '0; pa = '0; c = '0; hs = 1'b1; vs = 1'b1; bn = 1'b0; rgb = '0;
    if (k >= 1) begin
      p = (k - 1) / 2; h = p % ht; v = (p / ht) % vt;
      if (h < hv && v < vv) ra = pix_addr(h, v);
    end
    if (k >= 2) begin
      p = (k - 2) / 2; h = p % ht; v = (p / ht) % vt;
      hs = !(h >= hv + hf && h < hv + hf + hsw);
      vs = !(v >= vv + vf && v < vv + vf + vsw);
      bn = (h < hv && v < vv);
      if (bn) begin
        pa  = pix_addr(h, v);
        c   = sm ? mem_s[pa] : pa[2:0];
        rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
      end
    end
    fs = (k >= 2) && (k % 2 == 0) && ((k / 2) % (ht * vt) == 0);
    return {((k % 2) == 1), ra, hs, vs, bn, rgb, fs};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 2;
      if (d_bus !== RST_BUS) begin
        errors++; $display("FAIL reset_default: got %h expected %h", d_bus, RST_BUS);
      end
      if (s_bus !== RST_BUS) begin
        errors++; $display("FAIL reset_small: got %h expected %h", s_bus, RST_BUS);
      end
    end
  endtask

  task automatic test_lines();
    int hs_lo [2];
    hs_lo = '{0, 0};
    rst_d = 1'b0;
    rst_s = 1'b0;
    while (kd < 3210) begin
      @(negedge clk);
      checks++;
      if (d_bus !== model(1'b0, kd)) begin
        errors++; $display("FAIL scan_default k=%0d: got %h expected %h", kd, d_bus, model(1'b0, kd));
      end
      if (kd >= 2 && kd < 3202 && d_hs === 1'b0) hs_lo[(kd - 2) / 1600]++;
    end
    for (int l = 0; l < 2; l++) begin
      checks++;
      if (hs_lo[l] != 192) begin
        errors++; $display("FAIL hs_low_clk line%0d: got %0d expected 192", l, hs_lo[l]);
      end
    end
  endtask

  task automatic test_pixel_read();
    while (kd < 6409) @(negedge clk);
    checks++;
    if (d_raddr !== 15'd161) begin
      errors++; $display("FAIL addr_4_4: got %0d expected 161", d_raddr);
    end
    @(negedge clk);
    checks++;
    if ({d_r, d_g, d_b} !== 24'h0000FF) begin
      errors++; $display("FAIL rgb_4_4: got %h expected 0000ff", {d_r, d_g, d_b});
    end
  endtask

  task automatic test_blank_edge();
    while (kd < 9279) @(negedge clk);
    checks++;
    if (d_raddr !== 15'd319) begin
      errors++; $display("FAIL addr_639_5: got %0d expected 319", d_raddr);
    end
    @(negedge clk);
    checks++;
    if ({d_bn, d_r, d_g, d_b} !== {1'b1, 24'hFFFFFF}) begin
      errors++; $display("FAIL last_vis_pix: got %h expected 1ffffff", {d_bn, d_r, d_g, d_b});
    end
    @(negedge clk);
    checks++;
    if ({d_bn, d_r, d_g, d_b} !== {1'b1, 24'hFFFFFF}) begin
      errors++; $display("FAIL last_vis_pix_hold: got %h expected 1ffffff", {d_bn, d_r, d_g, d_b});
    end
    checks++;
    if (d_raddr !== 15'd0) begin
      errors++; $display("FAIL addr_640: got %0d expected 0", d_raddr);
    end
    @(negedge clk);
    checks++;
    if ({d_bn, d_r, d_g, d_b} !== 25'd0) begin
      errors++; $display("FAIL blank_640: got %h expected 0", {d_bn, d_r, d_g, d_b});
    end
    while (kd < 9400) begin
      @(negedge clk);
      checks++;
      if (d_raddr !== 15'd0) begin
        errors++; $display("FAIL addr_hblank k=%0d: got %0d expected 0", kd, d_raddr);
      end
    end
  endtask

  task automatic test_frame();
    int vs_lo, nfs;
    int fs_at [2];
    vs_lo = 0; nfs = 0; fs_at = '{-1, -1};
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    while (ks < 2 * S_FRAME_CLK + 20) begin
      @(negedge clk);
      checks++;
      if (s_bus !== model(1'b1, ks)) begin
        errors++; $display("FAIL scan_small k=%0d: got %h expected %h", ks, s_bus, model(1'b1, ks));
      end
      if (ks >= 2 && ks < S_FRAME_CLK + 2 && s_vs === 1'b0) vs_lo++;
      if (s_fs === 1'b1) begin
        if (nfs < 2) fs_at[nfs] = ks;
        nfs++;
      end
    end
    checks++;
    if (vs_lo != 2 * S_VS * S_HT) begin
      errors++; $display("FAIL vs_low_clk: got %0d expected %0d", vs_lo, 2 * S_VS * S_HT);
    end
    checks++;
    if (nfs != 2) begin
      errors++; $display("FAIL frame_start_count: got %0d expected 2", nfs);
    end
    checks++;
    if (fs_at[0] != S_FRAME_CLK || fs_at[1] - fs_at[0] != S_FRAME_CLK) begin
      errors++; $display("FAIL frame_start_period: got %0d,%0d expected %0d,%0d",
                         fs_at[0], fs_at[1], S_FRAME_CLK, 2 * S_FRAME_CLK);
    end
  endtask

  task automatic test_last_pixel();
    logic [2:0] c;
    // pixel (39,11) of the third frame
    while (ks < 2 * (2 * S_HT * S_VT + 11 * S_HT + 39) + 1) @(negedge clk);
    checks++;
    if (s_raddr !== 15'd329) begin
      errors++; $display("FAIL addr_last_vis: got %0d expected 329", s_raddr);
    end
    @(negedge clk);
    c = mem_s[329];
    checks++;
    if ({s_bn, s_r, s_g, s_b} !== {1'b1, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}}) begin
      errors++; $display("FAIL rgb_last_vis: got %h expected %h", {s_bn, s_r, s_g, s_b},
                         {1'b1, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}});
    end
    while (ks < 3 * S_FRAME_CLK) @(negedge clk);
    checks++;
    if ({s_raddr, s_fs} !== {15'd0, 1'b1}) begin
      errors++; $display("FAIL wrap_start: got %h expected 0001", {s_raddr, s_fs});
    end
    @(negedge clk);
    checks++;
    if (s_fs !== 1'b0) begin
      errors++; $display("FAIL frame_start_width: got %b expected 0", s_fs);
    end
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(50, 1500)) @(negedge clk);
      rst_d = 1'b1;
      rst_s = 1'b1;
      @(negedge clk);
      checks += 2;
      if (d_bus !== RST_BUS) begin
        errors++; $display("FAIL midreset_default: got %h expected %h", d_bus, RST_BUS);
      end
      if (s_bus !== RST_BUS) begin
        errors++; $display("FAIL midreset_small: got %h expected %h", s_bus, RST_BUS);
      end
      rst_d = 1'b0;
      rst_s = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({d_hs, d_vs, d_bn, s_hs, s_vs, s_bn} !== 6'b111111) begin
        errors++; $display("FAIL first_pixel_00: got %b expected 111111",
                           {d_hs, d_vs, d_bn, s_hs, s_vs, s_bn});
      end
      repeat (400) begin
        @(negedge clk);
        checks += 2;
        if (d_bus !== model(1'b0, kd)) begin
          errors++; $display("FAIL restart_default k=%0d: got %h expected %h", kd, d_bus, model(1'b0, kd));
        end
        if (s_bus !== model(1'b1, ks)) begin
          errors++; $display("FAIL restart_small k=%0d: got %h expected %h", ks, s_bus, model(1'b1, ks));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 19200; i++) mem_s[i] = 3'($urandom);
    test_reset();
    test_lines();
    test_pixel_read();
    test_blank_edge();
    test_frame();
    test_last_pixel();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
